token_draw_scheduler: RTL and testbench

Sequences and shares the single VGA plot port between the two player tokens. On a redraw request, it erases the token's old square and then plots the new square, streaming one pixel per clock into the `vga_adapter` x/y/colour/plot inputs. It round-robins between player 1 and player 2, replacing the free-running dual-token datapath. It sits between the position/coordinate LUT logic and the VGA adapter.

---
 rtl/token_draw_pkg.sv | 36 +++
 rtl/token_pixel_counter.sv | 56 +++++
 rtl/token_draw_scheduler.sv | 245 ++++++++++++++++++++++++
 tb/tb_token_draw_scheduler.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/token_draw_pkg.sv
// Shared types and defaults for the token draw scheduler.
//   state_t  : scheduler FSM states
//   player_t : player identity used by the arbiter and ack steering
//   DEF_*    : default token size and colours
//   idx_w    : width of a pixel index for a given token size
//   coord_add: 9-bit screen coordinate add, wrapping modulo 512
package token_draw_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ERASE = 3'd2,
        S_DRAW  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef enum logic {
        PLAYER_1 = 1'b0,
        PLAYER_2 = 1'b1
    } player_t;

    localparam int         DEF_TOKEN_SIZE   = 3;
    localparam logic [2:0] DEF_P1_COLOUR    = 3'b001;
    localparam logic [2:0] DEF_P2_COLOUR    = 3'b011;
    localparam logic [2:0] DEF_ERASE_COLOUR = 3'b111;

    // A 1x1 token still needs a 1-bit index so the ports stay non-empty.
    function automatic int idx_w(input int ts);
        return (ts > 1) ? $clog2(ts) : 1;
    endfunction

    function automatic logic [8:0] coord_add(input logic [8:0] base, input logic [8:0] off);
        return base + off;
    endfunction

endpackage

// File: rtl/token_pixel_counter.sv
// Row-major TOKEN_SIZE x TOKEN_SIZE pixel index generator.
//   clk, resetn : clock, asynchronous active-low reset
//   start       : current index is forced to (0,0) this cycle (restart)
//   en          : current index is consumed; advance to the next one
//   cx, cy      : current pixel index, cx changes fastest
//   last        : current index is (TS-1, TS-1)
// start acts on the current cycle's index so a restart and the first
// pixel of the new scan can be consumed in the same cycle. The scan wraps
// back to (0,0) after the last pixel.
module token_pixel_counter
    import token_draw_pkg::*;
#(
    parameter  int TOKEN_SIZE = DEF_TOKEN_SIZE,
    localparam int CW         = idx_w(TOKEN_SIZE)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          en,
    output logic [CW-1:0] cx,
    output logic [CW-1:0] cy,
    output logic          last
);

    localparam logic [CW-1:0] LAST_IDX = CW'(TOKEN_SIZE - 1);

    logic [CW-1:0] r_cx;
    logic [CW-1:0] r_cy;
    logic [CW-1:0] w_cx;
    logic [CW-1:0] w_cy;

    assign w_cx = start ? '0 : r_cx;
    assign w_cy = start ? '0 : r_cy;
    assign cx   = w_cx;
    assign cy   = w_cy;
    assign last = (w_cx == LAST_IDX) && (w_cy == LAST_IDX);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (en) begin
            if (w_cx == LAST_IDX) begin
                r_cx <= '0;
                r_cy <= (w_cy == LAST_IDX) ? '0 : w_cy + CW'(1);
            end else begin
                r_cx <= w_cx + CW'(1);
                r_cy <= w_cy;
            end
        end else if (start) begin
            r_cx <= '0;
            r_cy <= '0;
        end
    end

endmodule

// File: rtl/token_draw_scheduler.sv
// Shares one VGA plot port between two player tokens. A redraw erases the
// token's previous square (if it is on screen) and then plots the new one,
// one pixel per clock, arbitrating round-robin between the players.
//   clk, resetn          : clock, asynchronous active-low reset
//   clear                : synchronous new-game clear (aborts, forgets tokens)
//   p1_req/p1_x/p1_y     : player 1 redraw request and new top-left corner
//   p2_req/p2_x/p2_y     : player 2 redraw request and new top-left corner
//   p1_ack, p2_ack       : one-cycle pulse when that player's redraw is done
//   x, y, colour, plot   : registered pixel stream to the VGA adapter
//   busy                 : FSM is not idle
//   dbg_state            : current FSM state (state_t encoding)
//
// Handshake: pN_req is a level held with stable pN_x/pN_y until pN_ack
// pulses; the requester drops it on the edge that ends the ack cycle. A
// request withdrawn before it is granted is simply forgotten.
module token_draw_scheduler
    import token_draw_pkg::*;
#(
    parameter int         TOKEN_SIZE   = DEF_TOKEN_SIZE,
    parameter logic [2:0] P1_COLOUR    = DEF_P1_COLOUR,
    parameter logic [2:0] P2_COLOUR    = DEF_P2_COLOUR,
    parameter logic [2:0] ERASE_COLOUR = DEF_ERASE_COLOUR
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear,
    input  logic       p1_req,
    input  logic [8:0] p1_x,
    input  logic [8:0] p1_y,
    input  logic       p2_req,
    input  logic [8:0] p2_x,
    input  logic [8:0] p2_y,
    output logic       p1_ack,
    output logic       p2_ack,
    output logic [8:0] x,
    output logic [8:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic [2:0] dbg_state
);

    localparam int CW = idx_w(TOKEN_SIZE);

    state_t     r_state;
    state_t     w_nxt_state;
    player_t    r_grant;
    player_t    r_last_grant;
    player_t    w_grant;

    logic [8:0] r_new_x, r_new_y;
    logic [8:0] r_p1_old_x, r_p1_old_y, r_p2_old_x, r_p2_old_y;
    logic       r_p1_drawn, r_p2_drawn;

    logic [8:0] r_x, r_y;
    logic [2:0] r_colour;
    logic       r_plot;
    logic       r_pix_last;
    logic       r_p1_ack, r_p2_ack;

    logic [CW-1:0] w_cx, w_cy;
    logic          w_last;
    logic          w_cnt_start, w_cnt_en;
    logic          w_emit, w_erase_px, w_ack;

    logic [8:0] w_sel_x, w_sel_y;
    logic [8:0] w_draw_x, w_draw_y;
    logic [8:0] w_old_x, w_old_y;
    logic       w_drawn_sel;
    logic [8:0] w_base_x, w_base_y;
    logic [2:0] w_px_colour;

    // Round-robin on a tie: the player not served last wins.
    always_comb begin
        w_grant = PLAYER_1;
        if (p1_req && p2_req) begin
            w_grant = (r_last_grant == PLAYER_2) ? PLAYER_1 : PLAYER_2;
        end else if (p2_req) begin
            w_grant = PLAYER_2;
        end
    end

    assign w_sel_x     = (r_grant == PLAYER_1) ? p1_x : p2_x;
    assign w_sel_y     = (r_grant == PLAYER_1) ? p1_y : p2_y;
    assign w_old_x     = (r_grant == PLAYER_1) ? r_p1_old_x : r_p2_old_x;
    assign w_old_y     = (r_grant == PLAYER_1) ? r_p1_old_y : r_p2_old_y;
    assign w_drawn_sel = (r_grant == PLAYER_1) ? r_p1_drawn : r_p2_drawn;

    // The first draw pixel is registered at the end of LOAD, before
    // r_new_x/y hold the latched coordinate, so LOAD reads the inputs.
    assign w_draw_x = (r_state == S_LOAD) ? w_sel_x : r_new_x;
    assign w_draw_y = (r_state == S_LOAD) ? w_sel_y : r_new_y;

    token_pixel_counter #(
        .TOKEN_SIZE (TOKEN_SIZE)
    ) u_counter (
        .clk    (clk),
        .resetn (resetn),
        .start  (w_cnt_start),
        .en     (w_cnt_en),
        .cx     (w_cx),
        .cy     (w_cy),
        .last   (w_last)
    );

    // Outputs are registered, so each cycle prepares the pixel shown in
    // the NEXT cycle. r_pix_last marks that the pixel now on the port is
    // the last of its phase, which is when the phase must end.
    always_comb begin
        w_nxt_state = r_state;
        w_cnt_start = 1'b0;
        w_cnt_en    = 1'b0;
        w_emit      = 1'b0;
        w_erase_px  = 1'b0;
        w_ack       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (p1_req || p2_req) begin
                    w_nxt_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_cnt_start = 1'b1;
                w_cnt_en    = 1'b1;
                w_emit      = 1'b1;
                if (w_drawn_sel) begin
                    w_nxt_state = S_ERASE;
                    w_erase_px  = 1'b1;
                end else begin
                    w_nxt_state = S_DRAW;
                end
            end
            S_ERASE: begin
                w_cnt_en = 1'b1;
                w_emit   = 1'b1;
                if (r_pix_last) begin
                    w_nxt_state = S_DRAW;
                    w_cnt_start = 1'b1;
                end else begin
                    w_erase_px  = 1'b1;
                end
            end
            S_DRAW: begin
                if (r_pix_last) begin
                    w_nxt_state = S_DONE;
                    w_ack       = 1'b1;
                end else begin
                    w_cnt_en = 1'b1;
                    w_emit   = 1'b1;
                end
            end
            S_DONE: begin
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
        if (clear) begin
            w_nxt_state = S_IDLE;
            w_cnt_start = 1'b0;
            w_cnt_en    = 1'b0;
            w_emit      = 1'b0;
            w_erase_px  = 1'b0;
            w_ack       = 1'b0;
        end
    end

    assign w_base_x    = w_erase_px ? w_old_x : w_draw_x;
    assign w_base_y    = w_erase_px ? w_old_y : w_draw_y;
    assign w_px_colour = w_erase_px ? ERASE_COLOUR :
                         ((r_grant == PLAYER_1) ? P1_COLOUR : P2_COLOUR);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_colour   <= '0;
            r_plot     <= 1'b0;
            r_pix_last <= 1'b0;
            r_p1_ack   <= 1'b0;
            r_p2_ack   <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_plot     <= w_emit;
            r_pix_last <= w_emit && w_last;
            r_p1_ack   <= w_ack && (r_grant == PLAYER_1);
            r_p2_ack   <= w_ack && (r_grant == PLAYER_2);
            if (w_emit) begin
                r_x      <= coord_add(w_base_x, 9'(w_cx));
                r_y      <= coord_add(w_base_y, 9'(w_cy));
                r_colour <= w_px_colour;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_grant      <= PLAYER_1;
            r_last_grant <= PLAYER_2;
            r_new_x      <= '0;
            r_new_y      <= '0;
            r_p1_old_x   <= '0;
            r_p1_old_y   <= '0;
            r_p2_old_x   <= '0;
            r_p2_old_y   <= '0;
            r_p1_drawn   <= 1'b0;
            r_p2_drawn   <= 1'b0;
        end else if (clear) begin
            r_p1_drawn <= 1'b0;
            r_p2_drawn <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && (p1_req || p2_req)) begin
                r_grant <= w_grant;
            end
            if (r_state == S_LOAD) begin
                r_new_x <= w_sel_x;
                r_new_y <= w_sel_y;
            end
            if (r_state == S_DONE) begin
                r_last_grant <= r_grant;
                if (r_grant == PLAYER_1) begin
                    r_p1_old_x <= r_new_x;
                    r_p1_old_y <= r_new_y;
                    r_p1_drawn <= 1'b1;
                end else begin
                    r_p2_old_x <= r_new_x;
                    r_p2_old_y <= r_new_y;
                    r_p2_drawn <= 1'b1;
                end
            end
        end
    end

    assign x         = r_x;
    assign y         = r_y;
    assign colour    = r_colour;
    assign plot      = r_plot;
    assign p1_ack    = r_p1_ack;
    assign p2_ack    = r_p2_ack;
    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_token_draw_scheduler.sv
module tb_token_draw_scheduler;

    localparam int TS = 3;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       clear = 1'b0;
    logic       p1_req = 1'b0;
    logic [8:0] p1_x = '0;
    logic [8:0] p1_y = '0;
    logic       p2_req = 1'b0;
    logic [8:0] p2_x = '0;
    logic [8:0] p2_y = '0;
    logic       p1_ack, p2_ack;
    logic [8:0] x, y;
    logic [2:0] colour;
    logic       plot, busy;
    logic [2:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [20:0] exp_q[$];

    typedef struct {
        int         player;
        logic [8:0] nx;
        logic [8:0] ny;
        logic [2:0] col;
        bit         erase;
        logic [8:0] ox;
        logic [8:0] oy;
    } vec_t;

    vec_t vecs[6];

    token_draw_scheduler dut (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (clear),
        .p1_req    (p1_req),
        .p1_x      (p1_x),
        .p1_y      (p1_y),
        .p2_req    (p2_req),
        .p2_x      (p2_x),
        .p2_y      (p2_y),
        .p1_ack    (p1_ack),
        .p2_ack    (p2_ack),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear  = 1'b0;
        p1_req = 1'b0;
        p2_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_plot", 32'(plot), 32'd0);
        check("rst_xyc", 32'({x, y, colour}), 32'd0);
        check("rst_acks", 32'({p1_ack, p2_ack}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        resetn = 1'b1;
    endtask

    task automatic set_req(input int player, input logic [8:0] nx, input logic [8:0] ny);
        if (player == 1) begin
            p1_x = nx; p1_y = ny; p1_req = 1'b1;
        end else begin
            p2_x = nx; p2_y = ny; p2_req = 1'b1;
        end
    endtask

    // Request already raised; the next posedge is the IDLE edge that grants it.
    task automatic expect_stream(input int player, input logic [8:0] nx, input logic [8:0] ny,
                                 input logic [2:0] col, input bit erase,
                                 input logic [8:0] ox, input logic [8:0] oy);
        logic [20:0] exp;
        exp_q.delete();
        if (erase) begin
            for (int cy = 0; cy < TS; cy++)
                for (int cx = 0; cx < TS; cx++)
                    exp_q.push_back({9'(ox + 9'(cx)), 9'(oy + 9'(cy)), 3'b111});
        end
        for (int cy = 0; cy < TS; cy++)
            for (int cx = 0; cx < TS; cx++)
                exp_q.push_back({9'(nx + 9'(cx)), 9'(ny + 9'(cy)), col});
        @(posedge clk); #1;
        check("load_plot", 32'(plot), 32'd0);
        check("load_busy", 32'(busy), 32'd1);
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            @(posedge clk); #1;
            check("px_plot", 32'(plot), 32'd1);
            check("px_xyc", 32'({x, y, colour}), 32'(exp));
        end
        @(posedge clk); #1;
        check("done_plot", 32'(plot), 32'd0);
        check("done_busy", 32'(busy), 32'd1);
        check("done_acks", 32'({p1_ack, p2_ack}), (player == 1) ? 32'b10 : 32'b01);
        if (player == 1) p1_req = 1'b0;
        else             p2_req = 1'b0;
    endtask

    task automatic idle_check();
        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_acks", 32'({p1_ack, p2_ack}), 32'd0);
        check("idle_plot", 32'(plot), 32'd0);
    endtask

    initial begin
        //             player  nx       ny       col     erase ox       oy
        vecs[0] = '{1, 9'd40,  9'd200, 3'b001, 1'b0, 9'd0,   9'd0};
        vecs[1] = '{1, 9'd70,  9'd200, 3'b001, 1'b1, 9'd40,  9'd200};
        vecs[2] = '{2, 9'd100, 9'd50,  3'b011, 1'b0, 9'd0,   9'd0};
        vecs[3] = '{2, 9'd100, 9'd50,  3'b011, 1'b1, 9'd100, 9'd50};
        vecs[4] = '{1, 9'd0,   9'd0,   3'b001, 1'b1, 9'd70,  9'd200};
        vecs[5] = '{1, 9'd317, 9'd237, 3'b001, 1'b1, 9'd0,   9'd0};

        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_req(vecs[i].player, vecs[i].nx, vecs[i].ny);
            expect_stream(vecs[i].player, vecs[i].nx, vecs[i].ny, vecs[i].col,
                          vecs[i].erase, vecs[i].ox, vecs[i].oy);
            idle_check();
        end

        // Simultaneous requests: P1 wins the first tie, then alternation.
        do_reset();
        set_req(1, 9'd10, 9'd10);
        set_req(2, 9'd20, 9'd20);
        expect_stream(1, 9'd10, 9'd10, 3'b001, 1'b0, 9'd0, 9'd0);
        idle_check();
        expect_stream(2, 9'd20, 9'd20, 3'b011, 1'b0, 9'd0, 9'd0);
        idle_check();
        set_req(1, 9'd30, 9'd10);
        set_req(2, 9'd40, 9'd20);
        expect_stream(1, 9'd30, 9'd10, 3'b001, 1'b1, 9'd10, 9'd10);
        idle_check();
        expect_stream(2, 9'd40, 9'd20, 3'b011, 1'b1, 9'd20, 9'd20);
        idle_check();

        // Clear during the 4th draw pixel of a move.
        do_reset();
        set_req(1, 9'd40, 9'd200);
        expect_stream(1, 9'd40, 9'd200, 3'b001, 1'b0, 9'd0, 9'd0);
        idle_check();
        set_req(1, 9'd70, 9'd200);
        @(posedge clk); #1;
        check("clr_load_plot", 32'(plot), 32'd0);
        for (int k = 0; k < TS * TS; k++) begin
            @(posedge clk); #1;
            check("clr_erase", 32'({plot, colour}), 32'b1111);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("clr_draw", 32'({plot, colour}), 32'b1001);
        end
        check("clr_px3_xy", 32'({x, y}), 32'({9'd70, 9'd201}));
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clr_plot", 32'(plot), 32'd0);
        check("clr_busy", 32'(busy), 32'd0);
        check("clr_acks", 32'({p1_ack, p2_ack}), 32'd0);
        expect_stream(1, 9'd70, 9'd200, 3'b001, 1'b0, 9'd0, 9'd0);
        idle_check();

        // Asynchronous reset in the middle of an erase.
        set_req(2, 9'd100, 9'd100);
        expect_stream(2, 9'd100, 9'd100, 3'b011, 1'b0, 9'd0, 9'd0);
        idle_check();
        set_req(2, 9'd120, 9'd100);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("ar_erase", 32'({plot, colour}), 32'b1111);
        end
        #2;
        resetn = 1'b0;
        #1;
        check("ar_plot", 32'(plot), 32'd0);
        check("ar_xyc", 32'({x, y, colour}), 32'd0);
        check("ar_busy_acks", 32'({busy, p1_ack, p2_ack}), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        expect_stream(2, 9'd120, 9'd100, 3'b011, 1'b0, 9'd0, 9'd0);
        idle_check();

        // Out-of-contract x wraps modulo 512; the redraw still completes.
        set_req(1, 9'd511, 9'd10);
        expect_stream(1, 9'd511, 9'd10, 3'b001, 1'b0, 9'd0, 9'd0);
        idle_check();
        set_req(1, 9'd5, 9'd5);
        expect_stream(1, 9'd5, 9'd5, 3'b001, 1'b1, 9'd511, 9'd10);
        idle_check();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
